// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the five-requester mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int N_REQ = 5;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    localparam logic [SEL_W-1:0] SEL_A = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B = 3'd1;
    localparam logic [SEL_W-1:0] SEL_C = 3'd2;
    localparam logic [SEL_W-1:0] SEL_D = 3'd3;
    localparam logic [SEL_W-1:0] SEL_E = 3'd4;

endpackage

// File: rtl/mux_rr_pick.sv
// Round-robin winner search: the first set request bit strictly after ptr,
// wrapping 4 -> 0. With ptr = 4 this degenerates to lowest-index-wins.
module mux_rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    int idx;

    // Scan the five positions after ptr in wrap order; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter / sequencer for a 5:1 data mux feeding one sink.
// Each grant lasts up to BURST_LEN accepted beats, and one IDLE cycle
// always separates consecutive grants.
// Build option: MUX_RR_ARBITER_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) and drops the round-robin pointer register.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [N_REQ-1:0]  i_REQ,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    input  logic [DATA_W-1:0] i_C,
    input  logic [DATA_W-1:0] i_D,
    input  logic [DATA_W-1:0] i_E,
    input  logic              i_READY,
    output logic [SEL_W-1:0]  o_SEL,
    output logic [N_REQ-1:0]  o_GNT,
    output logic              o_VALID,
    output logic [DATA_W-1:0] o_DATA,
    output logic              o_LAST
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [N_REQ-1:0]   gnt;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic               req_sel;
    logic [DATA_W-1:0]  data_mux;
    logic               beat;

`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
    // A constant pointer of 4 makes the wrap search start at index 0.
    assign ptr = SEL_E;
`else
    // Pointer holds the last winner so the search starts just after it.
    always_ff @(posedge i_CLK) begin
        if (i_RST)
            ptr <= SEL_E;
        else if (state == IDLE && any_req)
            ptr <= winner;
    end
`endif

    mux_rr_pick u_pick (
        .req    (i_REQ),
        .ptr    (ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Request bit and data of the currently selected requester.
    always_comb begin
        req_sel  = 1'b0;
        data_mux = '0;
        case (sel)
            SEL_A: begin req_sel = i_REQ[0]; data_mux = i_A; end
            SEL_B: begin req_sel = i_REQ[1]; data_mux = i_B; end
            SEL_C: begin req_sel = i_REQ[2]; data_mux = i_C; end
            SEL_D: begin req_sel = i_REQ[3]; data_mux = i_D; end
            SEL_E: begin req_sel = i_REQ[4]; data_mux = i_E; end
            default: begin req_sel = 1'b0; data_mux = '0; end
        endcase
    end

    assign o_VALID = (state == XFER) && req_sel;
    assign o_DATA  = (state == XFER) ? data_mux : '0;
    assign o_LAST  = o_VALID && (cnt == CNT_LAST);
    assign beat    = o_VALID && i_READY;
    assign o_SEL   = sel;
    assign o_GNT   = gnt;

    // Grant FSM: arbitrate in IDLE, count beats in XFER, leave on the last
    // accepted beat or when the granted requester drops its request.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= IDLE;
            sel   <= SEL_A;
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= XFER;
                        sel   <= winner;
                        gnt   <= N_REQ'(1) << winner;
                        cnt   <= '0;
                    end
                end
                XFER: begin
                    if (!req_sel) begin
                        // Withdrawal: no beat this cycle, even if ready.
                        state <= IDLE;
                        gnt   <= '0;
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                        if (o_LAST) begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (DATA_W=4, BURST_LEN=4).
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [3:0] a, b, c, d, e;
    logic       ready;
    logic [2:0] sel;
    logic [4:0] gnt;
    logic       valid;
    logic [3:0] data;
    logic       last;

    int tests = 0;
    int fails = 0;

    mux_rr_arbiter #(.DATA_W(4), .BURST_LEN(4)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_REQ   (req),
        .i_A     (a),
        .i_B     (b),
        .i_C     (c),
        .i_D     (d),
        .i_E     (e),
        .i_READY (ready),
        .o_SEL   (sel),
        .o_GNT   (gnt),
        .o_VALID (valid),
        .o_DATA  (data),
        .o_LAST  (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] data_of(input int g);
        case (g)
            0: return a;
            1: return b;
            2: return c;
            3: return d;
            default: return e;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; req = '0; ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    // Run full 4-beat grants following the expected winner list.
    task automatic run_grants(input string tag, input int order[], input int n);
        tick();
        for (int k = 0; k < n; k++) begin
            tests++;
            if (sel !== 3'(order[k]) || gnt !== 5'(1 << order[k])) begin
                fails++;
                $display("FAIL %s grant%0d: sel=%0d gnt=%b want sel=%0d", tag, k, sel, gnt, order[k]);
            end
            for (int bt = 0; bt < 4; bt++) begin
                tests++;
                if (valid !== 1'b1 || data !== data_of(order[k]) || last !== (bt == 3)) begin
                    fails++;
                    $display("FAIL %s beat g%0d b%0d: v=%b d=%h l=%b want v=1 d=%h l=%b",
                             tag, k, bt, valid, data, last, data_of(order[k]), bt == 3);
                end
                tick();
            end
            tests++;
            if (gnt !== 5'b0 || valid !== 1'b0) begin
                fails++;
                $display("FAIL %s bubble%0d: gnt=%b v=%b want 0", tag, k, gnt, valid);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4; e = 4'h5;
        do_reset();
        tests++;
        if (sel !== 3'd0 || gnt !== 5'b0 || valid !== 1'b0 || data !== 4'h0 || last !== 1'b0) begin
            fails++;
            $display("FAIL reset: sel=%0d gnt=%b v=%b d=%h l=%b want all 0", sel, gnt, valid, data, last);
        end
    endtask

    task automatic test_single();
        int ord[];
        do_reset();
        a = 4'hA;
        req = 5'b00001;
        #1;
        tests++;
        if (gnt !== 5'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL single pre-grant: gnt=%b v=%b want 0", gnt, valid);
        end
        ord = new[1];
        ord[0] = 0;
        run_grants("single", ord, 1);
        req = '0;
        a = 4'h1;
    endtask

    task automatic test_rr_all();
        int ord[];
        do_reset();
        req = 5'b11111;
        ord = new[6];
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 4; ord[5] = 0;
        run_grants("rr_all", ord, 6);
        req = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        c = 4'h7;
        req = 5'b00100;
        tick();
        tests++;
        if (sel !== 3'd2 || gnt !== 5'b00100) begin
            fails++;
            $display("FAIL withdraw grant: sel=%0d gnt=%b want 2/00100", sel, gnt);
        end
        tick(); tick();
        req = 5'b11011;
        #1;
        tests++;
        if (valid !== 1'b0 || last !== 1'b0 || gnt !== 5'b00100) begin
            fails++;
            $display("FAIL withdraw cycle: v=%b l=%b gnt=%b want 0/0/00100", valid, last, gnt);
        end
        tick();
        tests++;
        if (gnt !== 5'b0) begin
            fails++;
            $display("FAIL withdraw idle: gnt=%b want 0", gnt);
        end
        tick();
        tests++;
        if (sel !== 3'd3 || gnt !== 5'b01000 || data !== d) begin
            fails++;
            $display("FAIL withdraw next: sel=%0d gnt=%b d=%h want 3/01000/%h", sel, gnt, data, d);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_stall();
        do_reset();
        c = 4'h9;
        req = 5'b00100;
        tick();
        tick();
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            c = 4'(4'hB + s);
            #1;
            tests++;
            if (valid !== 1'b1 || data !== 4'(4'hB + s) || last !== 1'b0 || sel !== 3'd2 || gnt !== 5'b00100) begin
                fails++;
                $display("FAIL stall%0d: v=%b d=%h l=%b sel=%0d gnt=%b want 1/%h/0/2/00100",
                         s, valid, data, last, sel, gnt, 4'(4'hB + s));
            end
            tick();
        end
        ready = 1'b1;
        for (int bt = 1; bt < 4; bt++) begin
            tests++;
            if (valid !== 1'b1 || last !== (bt == 3)) begin
                fails++;
                $display("FAIL stall resume b%0d: v=%b l=%b want 1/%b", bt, valid, last, bt == 3);
            end
            tick();
        end
        tests++;
        if (gnt !== 5'b0) begin
            fails++;
            $display("FAIL stall end: gnt=%b want 0", gnt);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 5'b00010;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tests++;
        if (gnt !== 5'b0 || valid !== 1'b0 || sel !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid: gnt=%b v=%b sel=%0d want 0", gnt, valid, sel);
        end
        rst = 1'b0;
        req = 5'b10001;
        tick();
        tests++;
        if (sel !== 3'd0 || gnt !== 5'b00001) begin
            fails++;
            $display("FAIL reset_mid regrant: sel=%0d gnt=%b want 0/00001", sel, gnt);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_prio_mode();
        int ord[];
        do_reset();
        req = 5'b10011;
        ord = new[4];
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
        ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 0;
`else
        ord[0] = 0; ord[1] = 1; ord[2] = 4; ord[3] = 0;
`endif
        run_grants("prio_mode", ord, 4);
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0; e = '0;
        test_reset();
        test_single();
        test_rr_all();
        test_withdraw();
        test_stall();
        test_reset_mid();
        test_prio_mode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
